// File: rtl/snn_pkg.sv
// Shared widths and write-port FSM state for the spiking synapse blocks.
package snn_pkg;
  localparam int CUR_W = 8;
  localparam int WT_W  = 8;
  localparam int SUM_W = 12;

  typedef enum logic {
    WR_IDLE   = 1'b0,
    WR_COMMIT = 1'b1
  } wr_state_t;
endpackage

// File: rtl/syn_decay_timer.sv
// Decay prescaler: counts 0..PERIOD-1 and pulses tick on the last count.
module syn_decay_timer #(
  parameter int PERIOD = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  logic [7:0] cnt;

  assign tick = (cnt == 8'(PERIOD - 1));

  always_ff @(posedge clk) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 8'd1;
  end
endmodule

// File: rtl/spike_synapse.sv
// Synaptic current integrator: weighted spike sum plus decaying current, clamped to 0..255.
// Define SPIKE_SYNAPSE_CLAMP_CNT_EN to add the saturating clamp_cnt output.
module spike_synapse
  import snn_pkg::*;
#(
  parameter int                     N_IN         = 4,
  parameter int                     DECAY_SHIFT  = 1,
  parameter int                     DECAY_PERIOD = 1,
  parameter logic signed [WT_W-1:0] WT_INIT      = 8'sd0,
  localparam int                    AW           = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_IN-1:0]         spike_in,
  input  logic                    wt_valid,
  output logic                    wt_ready,
  input  logic [AW-1:0]           wt_addr,
  input  logic signed [WT_W-1:0]  wt_data,
`ifdef SPIKE_SYNAPSE_CLAMP_CNT_EN
  output logic [7:0]              clamp_cnt,
`endif
  output logic [CUR_W-1:0]        current,
  output logic                    clamped
);
  logic [N_IN-1:0][WT_W-1:0] wt;
  logic [CUR_W-1:0]          syn, shifted, decayed;
  logic signed [SUM_W-1:0]   sum, dec_ext, total;
  logic                      tick, wr_en;
  wr_state_t                 state, state_nxt;

  syn_decay_timer #(.PERIOD(DECAY_PERIOD)) u_tmr (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Small values would never decay by the shift alone, so they step down by one.
  assign shifted = syn >> DECAY_SHIFT;
  always_comb begin
    decayed = syn;
    if (tick) begin
      if (syn != '0 && shifted == '0) decayed = syn - CUR_W'(1);
      else                            decayed = syn - shifted;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < N_IN; i++)
      if (spike_in[i]) sum = sum + {{(SUM_W-WT_W){wt[i][WT_W-1]}}, wt[i]};
  end

  assign dec_ext = {{(SUM_W-CUR_W){1'b0}}, decayed};
  assign total   = dec_ext + sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      syn     <= '0;
      clamped <= 1'b0;
    end else if (total < 0) begin
      syn     <= '0;
      clamped <= 1'b1;
    end else if (total > 12'sd255) begin
      syn     <= '1;
      clamped <= 1'b1;
    end else begin
      syn     <= total[CUR_W-1:0];
      clamped <= 1'b0;
    end
  end

  assign current = syn;

  always_ff @(posedge clk) begin
    if (rst) state <= WR_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      WR_IDLE:   if (wt_valid) state_nxt = WR_COMMIT;
      WR_COMMIT: state_nxt = WR_IDLE;
      default:   state_nxt = WR_IDLE;
    endcase
  end

  always_comb begin
    wt_ready = (state == WR_IDLE);
  end

  assign wr_en = wt_valid && wt_ready;

  // Out-of-range addresses match no lane, so the handshake completes without a write.
  for (genvar i = 0; i < N_IN; i++) begin : g_wt
    always_ff @(posedge clk) begin
      if (rst)                                wt[i] <= WT_INIT;
      else if (wr_en && wt_addr == AW'(i))    wt[i] <= wt_data;
    end
  end

`ifdef SPIKE_SYNAPSE_CLAMP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                           clamp_cnt <= '0;
    else if (clamped && clamp_cnt != '1) clamp_cnt <= clamp_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_spike_synapse.sv
// Randomized and directed bench for spike_synapse against an integer reference model.
module tb_spike_synapse;
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [3:0]        spike = '0;
  logic              wv = 1'b0;
  logic [1:0]        wa = '0;
  logic signed [7:0] wd = '0;
  logic [7:0]        cur0, cur1;
  logic              clp0, clp1, rdy0, rdy1;
`ifdef SPIKE_SYNAPSE_CLAMP_CNT_EN
  logic [7:0]        ccnt0, ccnt1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Instance 0: four inputs, decay every cycle. Instance 1: three inputs, decay every 4th cycle.
  int per[2] = '{1, 4};
  int nin[2] = '{4, 3};
  int m_syn[2], m_cnt[2], m_clamp[2], m_commit[2], m_ccnt[2];
  int m_wt[2][4];

  always #5 clk = ~clk;

  spike_synapse #(.N_IN(4), .DECAY_SHIFT(1), .DECAY_PERIOD(1), .WT_INIT(8'sd0)) dut (
    .clk(clk), .rst(rst), .spike_in(spike), .wt_valid(wv), .wt_ready(rdy0),
    .wt_addr(wa), .wt_data(wd),
`ifdef SPIKE_SYNAPSE_CLAMP_CNT_EN
    .clamp_cnt(ccnt0),
`endif
    .current(cur0), .clamped(clp0));

  spike_synapse #(.N_IN(3), .DECAY_SHIFT(1), .DECAY_PERIOD(4), .WT_INIT(8'sd0)) dut4 (
    .clk(clk), .rst(rst), .spike_in(spike[2:0]), .wt_valid(wv), .wt_ready(rdy1),
    .wt_addr(wa), .wt_data(wd),
`ifdef SPIKE_SYNAPSE_CLAMP_CNT_EN
    .clamp_cnt(ccnt1),
`endif
    .current(cur1), .clamped(clp1));

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one cycle from the rules, clock the DUTs, then compare everything.
  task automatic cyc();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_syn[k] = 0; m_cnt[k] = 0; m_clamp[k] = 0; m_commit[k] = 0; m_ccnt[k] = 0;
        for (int i = 0; i < 4; i++) m_wt[k][i] = 0;
      end else begin
        bit tick;
        int d, s, t;
        tick = (m_cnt[k] == per[k] - 1);
        d = m_syn[k];
        if (tick) begin
          if (d != 0 && d / 2 == 0) d = d - 1;
          else                      d = d - d / 2;
        end
        s = 0;
        for (int i = 0; i < nin[k]; i++) if (spike[i]) s += m_wt[k][i];
        t = d + s;
        m_clamp[k] = (t < 0 || t > 255) ? 1 : 0;
        m_syn[k]   = (t < 0) ? 0 : (t > 255) ? 255 : t;
        if (!m_commit[k] && wv) begin
          if (int'(wa) < nin[k]) m_wt[k][int'(wa)] = int'(wd);
          m_commit[k] = 1;
        end else m_commit[k] = 0;
        m_cnt[k] = tick ? 0 : m_cnt[k] + 1;
        if (m_clamp[k] != 0 && m_ccnt[k] < 255) m_ccnt[k]++;
      end
    end
    @(posedge clk);
    #1;
    chk("cur0", int'(cur0), m_syn[0]);
    chk("clp0", int'(clp0), m_clamp[0]);
    chk("rdy0", int'(rdy0), m_commit[0] ? 0 : 1);
    chk("cur1", int'(cur1), m_syn[1]);
    chk("clp1", int'(clp1), m_clamp[1]);
    chk("rdy1", int'(rdy1), m_commit[1] ? 0 : 1);
`ifdef SPIKE_SYNAPSE_CLAMP_CNT_EN
    chk("ccnt0", int'(ccnt0), m_ccnt[0]);
    chk("ccnt1", int'(ccnt1), m_ccnt[1]);
`endif
  endtask

  task automatic wr(input int a, input int d);
    wv = 1'b1; wa = 2'(a); wd = 8'(d);
    cyc();
    wv = 1'b0;
    cyc();
  endtask

  task automatic idle(input int n);
    spike = '0;
    repeat (n) cyc();
  endtask

  initial begin
    int seq[7] = '{20, 10, 5, 3, 2, 1, 0};

    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_cur", int'(cur0), 0);
    chk("rst_rdy", int'(rdy0), 1);
    chk("rst_clp", int'(clp0), 0);

    // Single spike through weight 40, then decay sequence.
    wr(0, 40);
    spike = 4'b0001; cyc(); spike = '0;
    chk("w40_cur", int'(cur0), 40);
    chk("w40_clp", int'(clp0), 0);
    foreach (seq[i]) begin
      cyc();
      chk("decay_seq", int'(cur0), seq[i]);
    end

    // Overflow clamp, then underflow clamp using the pre-write weight on the first cycle.
    idle(45);
    wr(0, 100); wr(1, 100); wr(2, 100); wr(3, 10);
    spike = 4'b0111; cyc(); spike = '0;
    chk("ovf_cur", int'(cur0), 255);
    chk("ovf_clp", int'(clp0), 1);
    idle(45);
    spike = 4'b1000; wv = 1'b1; wa = 2'd3; wd = -8'sd128;
    cyc();
    wv = 1'b0;
    chk("syn10_cur", int'(cur0), 10);
    cyc();
    spike = '0;
    chk("unf_cur", int'(cur0), 0);
    chk("unf_clp", int'(clp0), 1);

    // Write and spike to the same index in one cycle.
    idle(45);
    wr(1, 5);
    spike = 4'b0010; wv = 1'b1; wa = 2'd1; wd = 8'sd50;
    cyc();
    wv = 1'b0;
    chk("same_old", int'(cur0), 5);
    chk("same_rdy", int'(rdy0), 0);
    cyc();
    spike = '0;
    chk("same_new", int'(cur0), 53);

    // Period-4 decay: align so the spike lands on a tick, then hold 3 and halve on the 4th.
    idle(45);
    wr(0, 64);
    for (int i = 0; i < 8 && m_cnt[1] != 3; i++) cyc();
    spike = 4'b0001; cyc(); spike = '0;
    chk("p4_set", int'(cur1), 64);
    repeat (3) begin
      cyc();
      chk("p4_hold", int'(cur1), 64);
    end
    cyc();
    chk("p4_half", int'(cur1), 32);

    // Reset during COMMIT.
    idle(45);
    wr(1, 77);
    spike = 4'b0010; wv = 1'b1; wa = 2'd2; wd = 8'sd9;
    cyc();
    spike = '0; wv = 1'b0;
    chk("c77_cur", int'(cur0), 77);
    chk("c77_rdy", int'(rdy0), 0);
    rst = 1'b1; spike = 4'b1111;
    cyc();
    rst = 1'b0; spike = '0;
    chk("rstc_cur", int'(cur0), 0);
    chk("rstc_rdy", int'(rdy0), 1);
    spike = 4'b1111; cyc(); spike = '0;
    chk("rstc_wt", int'(cur0), 0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      spike = 4'($urandom);
      wv    = ($urandom_range(0, 3) == 0);
      wa    = 2'($urandom);
      wd    = 8'($urandom);
      rst   = ($urandom_range(0, 80) == 0);
      cyc();
    end
    rst = 1'b0; wv = 1'b0;
    idle(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
